// File: rtl/mem_copy_master_if.sv
// mem_copy_master_if: copy request/status signals plus the data-memory bus they drive
interface mem_copy_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] remaining;
  modport master (
    input  start, src_base, dst_base, len, mem_rdata,
    output mem_addr, mem_wdata, mem_wen, busy, done, remaining
  );
  modport slave (
    output start, src_base, dst_base, len, mem_rdata,
    input  mem_addr, mem_wdata, mem_wen, busy, done, remaining
  );
endinterface

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-serial block copy over the data-memory bus; MEM_COPY_PACE_EN adds a hold after IO writes
module mem_copy_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int PACE_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  mem_copy_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, PACE, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef MEM_COPY_PACE_EN
  localparam int CW = PACE_CYCLES > 1 ? $clog2(PACE_CYCLES) : 1;
  logic [CW-1:0] pace_cnt_q, pace_cnt_d;
  logic          pace_go;
  assign pace_go = PACE_CYCLES != 0 && dst_ptr_q[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11;
`else
  localparam int unused_pace_cycles = PACE_CYCLES;
`endif
  // bus and status outputs decode straight from registered state
  assign bus.mem_wen   = state_q == WRITE;
  assign bus.busy      = state_q == READ || state_q == WRITE || state_q == PACE;
  assign bus.done      = state_q == DONE;
  assign bus.mem_addr  = state_q == READ ? src_ptr_q : (state_q == IDLE || state_q == DONE) ? '0 : dst_ptr_q;
  assign bus.mem_wdata = data_q;
  assign bus.remaining = rem_q;
  // next-state: accept request, read one word, write it, optionally pace, repeat
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    data_d    = data_q;
`ifdef MEM_COPY_PACE_EN
    pace_cnt_d = pace_cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        src_ptr_d = bus.src_base;
        dst_ptr_d = bus.dst_base;
        rem_d     = bus.len;
        state_d   = bus.len == '0 ? DONE : READ;
      end
      READ: begin
        data_d  = bus.mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        src_ptr_d = src_ptr_q + 1'b1;
        dst_ptr_d = dst_ptr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
`ifdef MEM_COPY_PACE_EN
        pace_cnt_d = '0;
        state_d    = rem_q == ADDR_WIDTH'(1) ? DONE : pace_go ? PACE : READ;
`else
        state_d = rem_q == ADDR_WIDTH'(1) ? DONE : READ;
`endif
      end
`ifdef MEM_COPY_PACE_EN
      PACE: begin
        pace_cnt_d = pace_cnt_q + 1'b1;
        state_d    = pace_cnt_q == CW'(PACE_CYCLES - 1) ? READ : PACE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any copy in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      data_q    <= '0;
`ifdef MEM_COPY_PACE_EN
      pace_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
`ifdef MEM_COPY_PACE_EN
      pace_cnt_q <= pace_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: random and directed copies checked by a queue scoreboard against a copy model
module tb_mem_copy_master;
`ifdef MEM_COPY_PACE_EN
  localparam int PACE = 3;
`else
  localparam int PACE = 0;
`endif
  typedef struct {int t; logic [7:0] a; logic [7:0] d; logic [7:0] r;} wr_t;
  logic clk = 0;
  logic reset = 1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] switches = 8'h00;
  logic [7:0] leds;
  logic prev_wen = 0;
  wr_t wq[$];
  int dq[$];
  mem_copy_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();
  mem_copy_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .PACE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic bit io(input logic [7:0] a);
    return a[7:6] == 2'b11;
  endfunction
  // memory and IO model: captures writes and refreshes q on negedge
  always @(negedge clk) begin
    if (bus.mem_wen) begin
      if (io(bus.mem_addr)) leds <= bus.mem_wdata;
      else ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= io(bus.mem_addr) ? switches : ram[bus.mem_addr];
  end
  // monitor: every write and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_wen) begin
        checks++;
        if (prev_wen) begin
          errors++;
          $display("FAIL wen_back_to_back cyc=%0d", cyc);
        end else if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, bus.mem_addr, bus.mem_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (cyc != e.t || bus.mem_addr != e.a || bus.mem_wdata != e.d || bus.remaining != e.r) begin
            errors++;
            $display("FAIL write got cyc=%0d addr=%h data=%h rem=%0d want cyc=%0d addr=%h data=%h rem=%0d",
                     cyc, bus.mem_addr, bus.mem_wdata, bus.remaining, e.t, e.a, e.d, e.r);
          end
        end
      end
      if (bus.done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d", cyc);
        end else begin
          int e;
          e = dq.pop_front();
          if (cyc != e || bus.busy || bus.remaining != 0) begin
            errors++;
            $display("FAIL done got cyc=%0d busy=%b rem=%0d want cyc=%0d busy=0 rem=0", cyc, bus.busy, bus.remaining, e);
          end
        end
      end
    end
    prev_wen = bus.mem_wen;
  end
  // reference model: copy word by word on ref_mem and schedule writes/done in time
  task automatic model(input int k, input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                       input int lim, output int dn);
    int t;
    logic [7:0] sa, da, v;
    t = k;
    for (int i = 0; i < int'(n); i++) begin
      sa = 8'(int'(s) + i);
      da = 8'(int'(d) + i);
      t += 2;
      v = io(sa) ? switches : ref_mem[sa];
      if (i < lim) begin
        wq.push_back('{t, da, v, 8'(int'(n) - i)});
        if (!io(da)) ref_mem[da] = v;
      end
      if (i < int'(n) - 1 && io(da)) t += PACE;
    end
    dn = t + 1;
    if (lim >= int'(n)) dq.push_back(dn);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000 && (bus.busy || bus.done); i++) @(negedge clk);
    if (bus.busy || bus.done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout cyc=%0d busy=%b", cyc, bus.busy);
    end
  endtask
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                       input int lim, output int k, output int dn);
    wait_idle();
    k = cyc;
    bus.start = 1;
    bus.src_base = s;
    bus.dst_base = d;
    bus.len = n;
    model(k, s, d, n, lim, dn);
    @(negedge clk);
    bus.start = 0;
    bus.src_base = 8'($urandom);
    bus.dst_base = 8'($urandom);
    bus.len = 8'($urandom);
  endtask
  task automatic copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    int k, dn;
    issue(s, d, n, 256, k, dn);
  endtask
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  initial begin
    int k, dn, dn2;
    bus.start = 0;
    bus.src_base = 0;
    bus.dst_base = 0;
    bus.len = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_wen", 8'(bus.mem_wen), 8'h0);
    chk("reset_busy", 8'(bus.busy), 8'h0);
    chk("reset_done", 8'(bus.done), 8'h0);
    chk("reset_addr", bus.mem_addr, 8'h00);
    chk("reset_wdata", bus.mem_wdata, 8'h00);
    chk("reset_remaining", bus.remaining, 8'h00);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ram[8'h10 + i] = 8'(8'h11 * (i + 1));
      ref_mem[8'h10 + i] = ram[8'h10 + i];
    end
    copy(8'h10, 8'h40, 8'd4);
    copy(8'h10, 8'h40, 8'd0);
    copy(8'hFE, 8'h20, 8'd3);
    wait_idle();
    switches = 8'h5A;
    copy(8'hC0, 8'hC0, 8'd2);
    wait_idle();
    chk("leds", leds, 8'h5A);
    switches = 8'($urandom);
    issue(8'h10, 8'h40, 8'd4, 1, k, dn);
    while (cyc < k + 3) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("abort_wen", 8'(bus.mem_wen), 8'h0);
    chk("abort_busy", 8'(bus.busy), 8'h0);
    chk("abort_done", 8'(bus.done), 8'h0);
    chk("abort_remaining", bus.remaining, 8'h00);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    copy(8'h10, 8'h48, 8'd4);
    wait_idle();
    k = cyc;
    bus.start = 1;
    bus.src_base = 8'h30;
    bus.dst_base = 8'h34;
    bus.len = 8'd5;
    model(k, 8'h30, 8'h34, 8'd5, 256, dn);
    model(dn + 1, 8'h30, 8'h34, 8'd5, 256, dn2);
    for (int i = 0; i < 500 && cyc != dn + 1; i++) @(negedge clk);
    if (cyc != dn + 1) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout cyc=%0d want=%0d", cyc, dn + 1);
    end
    @(negedge clk);
    bus.start = 0;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) switches = 8'($urandom);
      copy(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 5000 && (wq.size() != 0 || dq.size() != 0 || bus.busy || bus.done); i++) @(negedge clk);
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain writes_left=%0d dones_left=%0d want 0 0", wq.size(), dq.size());
    end
    for (int i = 0; i < 256; i++) chk($sformatf("ram_%0h", i), ram[i], ref_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator for the MiniMIPS data memory: drives the same addr/data/wen/q interface the CPU uses.
- Copies a block of LEN words from a source address to a destination address, one word at a time.
- A destination in the IO region (addr[7:6] == 2'b11) writes the LEDs; a source in the IO region reads the switches.
- Used for board bring-up: memory dumps to LEDs, region initialisation and copies while the CPU is held off the bus.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 8, memory address width; IO region is addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11.
- PACE_CYCLES, 50000000, idle cycles after each IO-region write. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse/level; sampled only in IDLE.
- src_base  in  ADDR_WIDTH  first source address; latched on accept.
- dst_base  in  ADDR_WIDTH  first destination address; latched on accept.
- len  in  ADDR_WIDTH  word count, 0 allowed; latched on accept.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_wdata  out  DATA_WIDTH  write data to memory.
- mem_wen  out  1  write enable; memory captures on negedge.
- mem_rdata  in  DATA_WIDTH  memory q; valid one posedge after mem_addr is presented.
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse.
- remaining  out  ADDR_WIDTH  words not yet written.

Behaviour:
- States: IDLE, READ, WRITE, PACE, DONE. State, src_ptr, dst_ptr, remaining, data_reg and pace_cnt are posedge registers.
- All outputs decode directly from registers. No combinational path from inputs to outputs.
- Reset (async) values: state=IDLE, all pointers/counters/data_reg=0, mem_wen=0, mem_addr=0, mem_wdata=0, busy=0, done=0, remaining=0.
- IDLE:
  - start=1 latches src_base, dst_base and len.
  - len != 0: go to READ. len == 0: go to DONE with no memory access.
  - start=0: stay in IDLE.
- READ (1 cycle): mem_addr=src_ptr, mem_wen=0. Next posedge: data_reg<=mem_rdata, go to WRITE.
- WRITE (1 cycle): mem_addr=dst_ptr, mem_wdata=data_reg, mem_wen=1. Next posedge:
  - src_ptr+1, dst_ptr+1, remaining-1.
  - If remaining was 1: go to DONE.
  - Else if pacing applies: go to PACE.
  - Else: go to READ.
- PACE: count pace_cnt from 0 to PACE_CYCLES-1, then go to READ. mem_wen=0; mem_addr holds dst_ptr.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- busy=1 exactly in READ, WRITE and PACE. In IDLE and DONE, mem_addr=0 and mem_wdata=data_reg.
- start is ignored outside IDLE, including in DONE. A new request can be accepted the cycle after done.
- Pointers wrap modulo 2**ADDR_WIDTH (0xFF+1 -> 0x00). Wrapping into or out of the IO region is legal; IO decode applies per access.
- Overlapping regions: copy is strictly ascending and word-serial; forward-overlap corruption is expected, not detected.
- Latency: N>0 words, start accepted at posedge 0 -> WRITE cycles are 2, 4, ..., 2N; done high in cycle 2N+1 (unpaced).
- mem_wen is high for exactly one cycle per word, never in consecutive cycles.
- Reset mid-operation: mem_wen drops immediately and the copy aborts. Words already written stay; no done pulse.

Optional Feature:
- Macro: MEM_COPY_PACE_EN.
- Defined: PACE state is compiled in. After each WRITE whose dst_ptr is in the IO region, except the final word, wait PACE_CYCLES cycles so each LED value stays visible. PACE_CYCLES=0 behaves as undefined.
- Undefined: PACE state, pace_cnt and PACE_CYCLES are unused. WRITE always goes to READ or DONE, giving 2 cycles per word.

Test Plan:
- RAM[0x10..0x13]=11,22,33,44; start src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=11,22,33,44; mem_wen high in cycles 2,4,6,8; done pulse in cycle 9; remaining 4->0.
- len=0, src=0x10 dst=0x40 -> done in cycle 1, mem_wen never high, busy never high, RAM unchanged.
- src=0xFE dst=0x20 len=3 -> reads 0xFE, 0xFF, 0x00; RAM[0x20..0x22] correct; no X on mem_addr.
- src=0xC0 (switches=0x5A) dst=0xC0 len=2, MEM_COPY_PACE_EN, PACE_CYCLES=3 -> LEDs=0x5A twice; 3 PACE cycles after first write only; done in cycle 8.
- Reset asserted between posedges while in WRITE of word 2 of 4 -> mem_wen low immediately, busy=0, state IDLE, word 1 written, no done; new start afterwards completes normally.
- start held high through done -> second copy accepted one cycle after the done pulse, never during DONE.
